serial_subtractor4: RTL
=======================

Name: serial_subtractor4

Overview:
- Bit-serial ripple-borrow subtractor. Computes D = A - B - bin, LSB first, one bit per clock, with a start/busy/done handshake.
- It is the inverse-direction companion of the team's combinational 4-bit adder (A + B + cin -> S, cout), and uses the same operand/flag conventions.
- Used where area matters more than latency, and as a reference checker for adder results (S - B - cin must return A).

Parameters:
- WIDTH, 4, operand and result width in bits; legal range is 2 to 16.
- CW, $clog2(WIDTH)+1, width of the internal bit counter (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a subtraction; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when D and bout become valid.
- D  output  WIDTH  difference (A - B - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 when A < B + bin (unsigned).

Behaviour:
- Reset: when rst_n is 0 at a clock edge, state goes to IDLE and busy, done, D, bout, the counter and the shift registers all go to 0. Reset in the middle of an operation aborts it; no done pulse is issued and the partial result is discarded.
- States:
  - IDLE: start=1 latches A, B and bin, clears the counter, and moves to SHIFT. Otherwise the block stays in IDLE.
  - SHIFT: each cycle takes a = opA[0], b = opB[0], br = borrow register, then:
    - d = a^b^br
    - br_next = (~a&b) | (~(a^b)&br)
    - opA and opB shift right, d shifts into the result register at the MSB, and the counter increments.
    - When the counter reaches WIDTH-1 the last bit is processed and the state moves to DONE.
  - DONE: lasts one cycle. done=1; D is loaded from the result register and bout from the final borrow.
    - start=1 in DONE is accepted (back-to-back): operands are latched and the state goes to SHIFT.
    - Otherwise the state goes to IDLE.
- Latency: start is sampled at edge k. SHIFT covers edges k+1..k+WIDTH. done is high for exactly the one cycle after edge k+WIDTH, so the result is available WIDTH+1 cycles after start. Throughput is one result per WIDTH+1 cycles.
- busy=1 exactly while in SHIFT. start while busy is ignored and has no side effects.
- D and bout are registered. They hold the last completed result (including through IDLE and busy) until the next DONE, and are 0 after reset.
- Changes on A, B or bin after capture have no effect on the current operation.
- Boundary cases:
  - A=B, bin=0 gives D=0, bout=0.
  - A=0, B=0, bin=1 gives D = all ones, bout=1.
  - A = all ones, B=0, bin=0 gives D = all ones, bout=0.

Decomposition:
- Package sub_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
  - the default WIDTH constant.
- One natural sub-module: full_subtractor, a combinational 1-bit cell (a, b, br -> d, br_next). The top level instantiates it once and owns the state machine, counter and shift registers.
- The bench compares against the golden model {bout, D} = {1'b0, A} - B - bin, taken in WIDTH+1 bits.

Test Plan:
- Operands A=0111, B=0110, bin=0 -> D=0001, bout=0; done pulse 5 cycles after start; busy high for 4 cycles.
- Operands A=1000, B=1001, bin=0 -> D=1111, bout=1.
- Operands A=1100, B=1000, bin=1 -> D=0011, bout=0. Then, in the DONE cycle, start with A=0101, B=1010, bin=1 -> D=1010, bout=1, with no IDLE gap.
- Operands A=0000, B=0001, bin=1 -> D=1110, bout=1. During SHIFT, assert start with A=1111, B=0000 -> it is ignored; exactly one done pulse and the original result.
- Start with A=1111, B=0001; drive rst_n=0 on the 2nd SHIFT cycle -> next cycle busy=0, done=0, D=0000, bout=0; no done pulse follows.
- Random sweep of all 256 {A,B} pairs with both bin values, checked against the golden model -> zero mismatches; done pulses are exactly one cycle wide.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  localparam int SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor4_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - br with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic br_next
);

  assign d       = a ^ b ^ br;
  assign br_next = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock.
module serial_subtractor4
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             accept;
  logic             last;
  logic             bit_d;
  logic             br_nx;

  full_subtractor u_fs (
    .a      (opa_q[0]),
    .b      (opb_q[0]),
    .br     (br_q),
    .d      (bit_d),
    .br_next(br_nx)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The final bit is folded straight into D/bout so they are valid in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      opa_q <= A;
      opb_q <= B;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      opa_q <= opa_q >> 1;
      opb_q <= opb_q >> 1;
      br_q  <= br_nx;
      res_q <= {bit_d, res_q[WIDTH-1:1]};
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        d_q    <= {bit_d, res_q[WIDTH-1:1]};
        bout_q <= br_nx;
      end
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign bout = bout_q;

endmodule
